// File: rtl/ring_tx_serializer.sv
// Ring-side transmitter: builds a 16-bit even-parity frame from the selected source and
// shifts it out MSB first with a start bit and a stop bit, BIT_CYCLES clocks per bit.
module ring_tx_serializer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic        Clk_R,
  input  logic        Rst_n,
  input  logic        rc_has_data,
  input  logic [2:0]  tx_data_select,
  input  logic [3:0]  ack_addr,
  input  logic [14:0] fwd_frame,
  input  logic [2:0]  node_type,
  input  logic [3:0]  node_addr,
  input  logic [7:0]  node_data,
  output logic        Tx_Out,
  output logic        tx_ready,
  output logic        tx_done,
  output logic        tx_err
);

  localparam logic [7:0] BaudLast     = 8'(BIT_CYCLES - 1);
  localparam logic [7:0] BaudStopLast = 8'(BIT_CYCLES - 2);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q;
  logic [7:0]  baud_q;
  logic [3:0]  bit_q;
  logic [15:0] shift_q;
  logic        tx_out_q, ready_q, done_q, err_q;

  logic [14:0] body;
  logic        body_valid;
  logic [15:0] frame;

  always_comb begin
    body       = '0;
    body_valid = 1'b1;
    case (tx_data_select)
      3'd0:    body = {3'b000, ack_addr, 8'h00};
      3'd1:    body = {3'b011, ack_addr, 8'h00};
      3'd2:    body = fwd_frame;
      3'd3:    body = {3'b111, 4'h0, 8'h00};
      3'd4: begin
        body       = {node_type, node_addr, node_data};
        body_valid = (node_type == 3'b010) || (node_type == 3'b001);
      end
      default: body_valid = 1'b0;
    endcase
  end

  assign frame = {body, ^body};

  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_out_q <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_out_q <= 1'b1;
          ready_q  <= 1'b1;
          if (rc_has_data && ready_q) begin
            if (body_valid) begin
              shift_q  <= frame;
              baud_q   <= '0;
              bit_q    <= '0;
              state_q  <= StStart;
              tx_out_q <= 1'b0;
              ready_q  <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StStart: begin
          if (baud_q == BaudLast) begin
            baud_q   <= '0;
            state_q  <= StData;
            tx_out_q <= shift_q[15];
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end
        StData: begin
          if (baud_q == BaudLast) begin
            baud_q  <= '0;
            shift_q <= {shift_q[14:0], 1'b0};
            if (bit_q == 4'd15) begin
              bit_q    <= '0;
              state_q  <= StStop;
              tx_out_q <= 1'b1;
            end else begin
              bit_q    <= bit_q + 4'd1;
              tx_out_q <= shift_q[14];
            end
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end
        StStop: begin
          // Last stop-bit cycle is spent in idle so a new load can follow with no gap.
          if (baud_q == BaudStopLast) begin
            baud_q  <= '0;
            state_q <= StIdle;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            baud_q <= baud_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Tx_Out   = tx_out_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;
  assign tx_err   = err_q;

endmodule
